// File: rtl/tdes_pkg.sv
// Shared widths, FSM state type and pass encodings for the two-key 3DES sequencer.
package tdes_pkg;

  localparam int BLK_W = 64;
  localparam int KEY_W = 56;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] PASS_0 = 2'd0;
  localparam logic [1:0] PASS_1 = 2'd1;
  localparam logic [1:0] PASS_2 = 2'd2;

endpackage

// File: rtl/tdes_pass_sel.sv
// Maps the current pass and latched mode/keys to the DES core key and direction.
module tdes_pass_sel
  import tdes_pkg::*;
(
  input  logic [1:0]       pass,
  input  logic             mode_r,
  input  logic [KEY_W-1:0] k1_r,
  input  logic [KEY_W-1:0] k2_r,
  output logic [KEY_W-1:0] des_key,
  output logic             des_e
);

  // The middle pass uses key2 and the opposite direction (EDE / DED).
  always_comb begin
    des_key = k1_r;
    des_e   = ~mode_r;
    if (pass == PASS_1) begin
      des_key = k2_r;
      des_e   = mode_r;
    end
  end

endmodule

// File: rtl/tdes_sequencer.sv
// Runs two-key Triple-DES by driving one external DES core through three passes,
// holding intermediate results in its own data register.
module tdes_sequencer
  import tdes_pkg::*;
#(
  parameter int unsigned DES_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_text,
  input  logic             in_decrypt,
  input  logic [KEY_W-1:0] key1,
  input  logic [KEY_W-1:0] key2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_text,
  output logic [BLK_W-1:0] des_in,
  output logic [KEY_W-1:0] des_key,
  output logic             des_e,
  input  logic [BLK_W-1:0] des_out,
  output logic             busy,
  output logic [1:0]       pass
);

  localparam logic [3:0] LAST_WCNT = 4'(DES_LAT - 1);

  state_t           r_state;
  logic [BLK_W-1:0] r_data;
  logic [KEY_W-1:0] r_k1;
  logic [KEY_W-1:0] r_k2;
  logic             r_mode;
  logic [1:0]       r_pass;
  logic [3:0]       r_wcnt;
  logic             r_out_valid;
  logic             r_busy;
  logic             w_accept;

  // Ready in DONE when the sink drains this cycle, so a new block can follow immediately.
  assign in_ready = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_data      <= '0;
      r_k1        <= '0;
      r_k2        <= '0;
      r_mode      <= 1'b0;
      r_pass      <= PASS_0;
      r_wcnt      <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_data      <= in_text;
            r_k1        <= key1;
            r_k2        <= key2;
            r_mode      <= in_decrypt;
            r_pass      <= PASS_0;
            r_wcnt      <= '0;
            r_state     <= RUN;
            r_busy      <= 1'b1;
            r_out_valid <= 1'b0;
          end else if (r_state == DONE && out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        RUN: begin
          if (r_wcnt == LAST_WCNT) begin
            r_data <= des_out;
            r_wcnt <= '0;
            if (r_pass == PASS_2) begin
              r_pass      <= PASS_0;
              r_state     <= DONE;
              r_busy      <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_pass <= r_pass + 2'd1;
            end
          end else begin
            r_wcnt <= r_wcnt + 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  tdes_pass_sel u_pass_sel (
    .pass    (r_pass),
    .mode_r  (r_mode),
    .k1_r    (r_k1),
    .k2_r    (r_k2),
    .des_key (des_key),
    .des_e   (des_e)
  );

  assign des_in    = r_data;
  assign out_text  = r_data;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign pass      = r_pass;

endmodule

// File: tb/tb_tdes_sequencer.sv
// Directed bench for tdes_sequencer with arithmetic stub DES cores at latencies 1 and 4.
module tb_tdes_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid1, in_valid4;
  logic [63:0] in_text;
  logic        in_decrypt;
  logic [55:0] key1, key2;
  logic        out_ready;

  logic        in_ready1, out_valid1, des_e1, busy1;
  logic [63:0] out_text1, des_in1, des_out1;
  logic [55:0] des_key1;
  logic [1:0]  pass1;

  logic        in_ready4, out_valid4, des_e4, busy4;
  logic [63:0] out_text4, des_in4, des_out4;
  logic [55:0] des_key4;
  logic [1:0]  pass4;

  logic [63:0] pipe4 [0:2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [63:0] stub(input logic [63:0] din, input logic [55:0] k, input logic e);
    return e ? (din + {8'd0, k}) : (din - {8'd0, k});
  endfunction

  // Operand is valid DES_LAT-1 register stages before the sequencer samples des_out.
  assign des_out1 = stub(des_in1, des_key1, des_e1);
  always @(posedge clk) begin
    pipe4[0] <= stub(des_in4, des_key4, des_e4);
    pipe4[1] <= pipe4[0];
    pipe4[2] <= pipe4[1];
  end
  assign des_out4 = pipe4[2];

  tdes_sequencer #(.DES_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_text(in_text), .in_decrypt(in_decrypt), .key1(key1), .key2(key2),
    .out_valid(out_valid1), .out_ready(out_ready), .out_text(out_text1),
    .des_in(des_in1), .des_key(des_key1), .des_e(des_e1), .des_out(des_out1),
    .busy(busy1), .pass(pass1)
  );

  tdes_sequencer #(.DES_LAT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_text(in_text), .in_decrypt(in_decrypt), .key1(key1), .key2(key2),
    .out_valid(out_valid4), .out_ready(out_ready), .out_text(out_text4),
    .des_in(des_in4), .des_key(des_key4), .des_e(des_e4), .des_out(des_out4),
    .busy(busy4), .pass(pass4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; in_valid1 = 1'b0; in_valid4 = 1'b0; in_text = '0;
    in_decrypt = 1'b0; key1 = '0; key2 = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid1), 64'd0);
    chk("rst_busy", 64'(busy1), 64'd0);
    chk("rst_pass", 64'(pass1), 64'd0);
    chk("rst_des_in", des_in1, 64'd0);
    chk("rst_des_key", 64'(des_key1), 64'd0);
    chk("rst_des_e", 64'(des_e1), 64'd1);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 64'(in_ready1), 64'd1);
    chk("rst_in_ready4", 64'(in_ready4), 64'd1);

    // Encrypt 0x10 / 5 / 3 at latency 1
    in_text = 64'h10; key1 = 56'd5; key2 = 56'd3; in_decrypt = 1'b0; in_valid1 = 1'b1;
    #1 chk("enc_in_ready", 64'(in_ready1), 64'd1);
    tick(); in_valid1 = 1'b0;
    chk("enc_busy", 64'(busy1), 64'd1);
    chk("enc_p0_pass", 64'(pass1), 64'd0);
    chk("enc_p0_des_in", des_in1, 64'h10);
    chk("enc_p0_key", 64'(des_key1), 64'd5);
    chk("enc_p0_e", 64'(des_e1), 64'd1);
    chk("enc_p0_out_valid", 64'(out_valid1), 64'd0);
    tick();
    chk("enc_p1_pass", 64'(pass1), 64'd1);
    chk("enc_p1_des_in", des_in1, 64'h15);
    chk("enc_p1_key", 64'(des_key1), 64'd3);
    chk("enc_p1_e", 64'(des_e1), 64'd0);
    tick();
    chk("enc_p2_pass", 64'(pass1), 64'd2);
    chk("enc_p2_des_in", des_in1, 64'h12);
    chk("enc_p2_key", 64'(des_key1), 64'd5);
    chk("enc_p2_e", 64'(des_e1), 64'd1);
    tick();
    chk("enc_out_valid", 64'(out_valid1), 64'd1);
    chk("enc_out_text", out_text1, 64'h17);
    chk("enc_done_busy", 64'(busy1), 64'd0);
    chk("enc_done_pass", 64'(pass1), 64'd0);
    chk("enc_done_in_ready", 64'(in_ready1), 64'd0);
    out_ready = 1'b1;
    #1 chk("enc_drain_in_ready", 64'(in_ready1), 64'd1);
    tick(); out_ready = 1'b0;
    chk("enc_idle_out_valid", 64'(out_valid1), 64'd0);

    // Decrypt same operands
    in_decrypt = 1'b1; in_valid1 = 1'b1;
    tick(); in_valid1 = 1'b0;
    chk("dec_p0_e", 64'(des_e1), 64'd0);
    chk("dec_p0_key", 64'(des_key1), 64'd5);
    chk("dec_p0_des_in", des_in1, 64'h10);
    tick();
    chk("dec_p1_e", 64'(des_e1), 64'd1);
    chk("dec_p1_key", 64'(des_key1), 64'd3);
    chk("dec_p1_des_in", des_in1, 64'h0B);
    tick();
    chk("dec_p2_e", 64'(des_e1), 64'd0);
    chk("dec_p2_key", 64'(des_key1), 64'd5);
    chk("dec_p2_des_in", des_in1, 64'h0E);
    tick();
    chk("dec_out_valid", 64'(out_valid1), 64'd1);
    chk("dec_out_text", out_text1, 64'h09);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Latency 4: encrypt 0x100 / 1 / 1
    in_text = 64'h100; key1 = 56'd1; key2 = 56'd1; in_decrypt = 1'b0; in_valid4 = 1'b1;
    tick(); in_valid4 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("lat4_pass_c%0d", c), 64'(pass4), 64'(c / 4));
      chk($sformatf("lat4_des_in_c%0d", c), des_in4, ((c / 4) == 1) ? 64'h101 : 64'h100);
      chk($sformatf("lat4_out_valid_c%0d", c), 64'(out_valid4), 64'd0);
      tick();
    end
    chk("lat4_out_valid", 64'(out_valid4), 64'd1);
    chk("lat4_out_text", out_text4, 64'h101);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("lat4_drained", 64'(out_valid4), 64'd0);

    // Backpressure followed by same-edge handoff
    in_text = 64'h10; key1 = 56'd5; key2 = 56'd3; in_decrypt = 1'b0; in_valid1 = 1'b1;
    tick(); in_valid1 = 1'b0;
    tick(); tick(); tick();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_out_valid_%0d", i), 64'(out_valid1), 64'd1);
      chk($sformatf("bp_out_text_%0d", i), out_text1, 64'h17);
      chk($sformatf("bp_in_ready_%0d", i), 64'(in_ready1), 64'd0);
      tick();
    end
    in_decrypt = 1'b1; in_valid1 = 1'b1; out_ready = 1'b1;
    #1 chk("b2b_in_ready", 64'(in_ready1), 64'd1);
    tick(); in_valid1 = 1'b0; out_ready = 1'b0;
    chk("b2b_busy", 64'(busy1), 64'd1);
    chk("b2b_out_valid", 64'(out_valid1), 64'd0);
    chk("b2b_pass", 64'(pass1), 64'd0);
    chk("b2b_des_e", 64'(des_e1), 64'd0);
    tick(); tick(); tick();
    chk("b2b_result_valid", 64'(out_valid1), 64'd1);
    chk("b2b_result", out_text1, 64'h09);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Reset during pass 1
    in_decrypt = 1'b0; in_valid1 = 1'b1;
    tick(); in_valid1 = 1'b0;
    tick();
    chk("rm_pass1", 64'(pass1), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_busy", 64'(busy1), 64'd0);
    chk("rm_pass", 64'(pass1), 64'd0);
    chk("rm_des_in", des_in1, 64'd0);
    chk("rm_des_key", 64'(des_key1), 64'd0);
    chk("rm_des_e", 64'(des_e1), 64'd1);
    chk("rm_out_valid", 64'(out_valid1), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rm_in_ready", 64'(in_ready1), 64'd1);
    tick(); tick(); tick();
    chk("rm_no_valid", 64'(out_valid1), 64'd0);
    in_valid1 = 1'b1;
    tick(); in_valid1 = 1'b0;
    tick(); tick(); tick();
    chk("rm_fresh_valid", 64'(out_valid1), 64'd1);
    chk("rm_fresh_text", out_text1, 64'h17);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Inputs changed after accept must not affect the result
    in_valid1 = 1'b1;
    tick(); in_valid1 = 1'b0;
    key1 = 56'hAA; key2 = 56'h77; in_decrypt = 1'b1; in_text = 64'hFFFF;
    tick();
    key1 = 56'h12; key2 = 56'h34; in_decrypt = 1'b0;
    tick(); tick();
    chk("tog_valid", 64'(out_valid1), 64'd1);
    chk("tog_text", out_text1, 64'h17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
